fc_feed_ctrl: RTL
=================

# fc_feed_ctrl

Feeder for the fully-connected stage of the VGG16 accelerator. On a start pulse it streams the flattened feature vector from the feature buffer (synchronous RAM, 1-cycle read latency) into the FC pipeline as `valid_in_FC`/`fc_data`. It then counts the `valid_out` pulses returned by the FC valid-delay chain and signals `done` once every issued element has emerged. It is the sending end of the valid chain that the FC control pipeline delays by 8 cycles.

## Interface
- `DATA_W`, 16: activation word width.
- `N_IN`, 25088: elements per vector (512×7×7); legal range 1..2^ADDR_W.
- `ADDR_W`, 15: feature-buffer address width.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `start`  in  1: begin one vector; sampled only in IDLE.
- `hold`  in  1: pause fetch while high (FETCH only).
- `rd_en`  out  1: feature-buffer read strobe.
- `rd_addr`  out  ADDR_W: read address.
- `rd_data`  in  DATA_W: RAM data, valid the cycle after `rd_en`.
- `valid_in_FC`  out  1: element valid into the FC pipeline.
- `fc_data`  out  DATA_W: element value.
- `fc_last`  out  1: marks the final element; high only with `valid_in_FC`.
- `fc_valid_out`  in  1: delayed valid returned from the FC chain.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: 1-cycle pulse when all returns are received.
- `err`  out  1: sticky protocol-error flag.

## Operation
- **States:**
  - IDLE: `start`=1 → FETCH.
  - FETCH: after the read for address N_IN−1 is issued → DRAIN.
  - DRAIN: return count = N_IN → DONE.
  - DONE: unconditional → IDLE.
- **FETCH, `hold`=0:** issue `rd_en`=1 with `rd_addr` = issue count, then increment the issue count.
- **FETCH, `hold`=1:** `rd_en`=0 and `rd_addr` holds. `hold` is ignored in every other state.
- **Data path:** `valid_in_FC`/`fc_data` are `rd_en`/`rd_data` registered one cycle after the RAM output. `fc_last` is set when the issued address was N_IN−1.
- **Return counter (ADDR_W+1 bits):**
  - Increments on `fc_valid_out` in FETCH or DRAIN.
  - Returns may begin while FETCH is still running.
  - Clears on entry to FETCH.
- **`done`** is high exactly during the DONE state.
- **`err`** sets on `fc_valid_out`=1 in IDLE or DONE. It clears only on reset.
- **Ignored inputs:** `start` while busy; `start` asserted in the DONE cycle. A new vector needs `start` in IDLE.
- **Pipeline ownership:** the feeder never asserts `valid_in_FC` outside FETCH/DRAIN-tail reads; data is never dropped.

## Timing
- **Reset:** `rst`=0 at an edge forces IDLE and clears both counters. All outputs read 0: `rd_en`, `rd_addr`, `valid_in_FC`, `fc_data`, `fc_last`, `busy`, `done`, `err`.
- **Reset mid-vector:** in-flight RAM data is discarded, and no `valid_in_FC` is asserted after reset.
- **Start sequence:** `start` high in cycle 0 → `busy` and `rd_en` high in cycle 1 (`rd_addr`=0) → `valid_in_FC` high in cycle 3.
- **Read-to-FC latency:** fixed at 2 cycles, including across `hold` gaps (gaps propagate unchanged).
- **Throughput:** one element per cycle with `hold`=0.
  - Last read in cycle N_IN; DRAIN from cycle N_IN+1.
  - `fc_last` in cycle N_IN+2.
  - With the 8-cycle FC chain, the final return arrives in cycle N_IN+10 and `done` pulses in cycle N_IN+11.
- **Simultaneous events:**
  - `fc_valid_out` in the same cycle as the FETCH→DRAIN transition is counted.
  - `hold` rising in the same cycle as the last issue has no effect.

## Structure
- Package `fc_pkg`:
  - state enum `fc_feed_state_t` {IDLE, FETCH, DRAIN, DONE};
  - constant `FC_PIPE_LAT` = 8 (bench use);
  - default `FC_DATA_W`/`FC_N_IN`.
- Single module, no sub-module. The two counters and the 1-deep read register are inline.

## Test plan
- **Basic, N_IN=4:** RAM holds 10,20,30,40; `start` at cycle 0; bench runs an 8-cycle valid delay → `valid_in_FC` in cycles 3–6 with data 10,20,30,40, `fc_last` in cycle 6, `done` in cycle 15, `err`=0.
- **Hold, N_IN=4:** `hold`=1 in cycles 2–3 → `rd_addr` sequence 0,1,1,1,2,3 (`rd_en`=0 while held); `valid_in_FC` pattern 1,0,0,1,1,1 starting cycle 3; data order preserved; `done` two cycles later than the basic case.
- **Reset mid-vector:** `rst`=0 in cycle 4 of an N_IN=8 run → all outputs 0 from cycle 5. A new `start` then gives a full 8-element run starting at `rd_addr`=0.
- **Ignored start:** `start` pulses in cycles 2 and 6 during a busy run → ignored, single `done`. Stray `fc_valid_out` in IDLE → `err`=1, held until reset.
- **Edge cases:** N_IN=1 → one read, `fc_last` on the first and only `valid_in_FC`, `done` in cycle 12. Back-to-back `start` in the cycle after `done` → second run starts normally.

Source files
------------

// File: rtl/fc_pkg.sv
// fc_pkg: shared state type and default sizes for the FC feeder
package fc_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fc_feed_state_t;
  localparam int FC_DATA_W   = 16;
  localparam int FC_N_IN     = 25088;
  localparam int FC_ADDR_W   = 15;
  localparam int FC_PIPE_LAT = 8;
endpackage

// File: rtl/fc_feed_ctrl.sv
// fc_feed_ctrl: streams one feature vector from the buffer into the FC pipeline and waits for all returns
module fc_feed_ctrl
  import fc_pkg::*;
#(
  parameter int DATA_W = FC_DATA_W,
  parameter int N_IN   = FC_N_IN,
  parameter int ADDR_W = FC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              valid_in_FC,
  output logic [DATA_W-1:0] fc_data,
  output logic              fc_last,
  input  logic              fc_valid_out,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);
  localparam logic [ADDR_W:0]   N_RET     = (ADDR_W + 1)'(N_IN);
  fc_feed_state_t    r_state;
  fc_feed_state_t    w_state_nxt;
  logic [ADDR_W-1:0] r_issue;
  logic [ADDR_W:0]   r_ret;
  logic [ADDR_W:0]   w_ret_nxt;
  logic              r_v1;
  logic              r_l1;
  logic              w_start_go;
  logic              w_last_issue;
  logic              w_count;
  assign w_start_go   = (r_state == IDLE) && start;
  assign rd_en        = (r_state == FETCH) && !hold;
  assign rd_addr      = r_issue;
  assign w_last_issue = rd_en && (r_issue == LAST_ADDR);
  assign w_count      = fc_valid_out && ((r_state == FETCH) || (r_state == DRAIN));
  // DRAIN ends on the cycle the final return arrives, so the look-ahead count is used
  assign w_ret_nxt    = r_ret + (ADDR_W + 1)'(w_count);
  assign w_state_nxt  = (r_state == IDLE)  ? (start ? FETCH : IDLE) :
                        (r_state == FETCH) ? (w_last_issue ? DRAIN : FETCH) :
                        (r_state == DRAIN) ? ((w_ret_nxt == N_RET) ? DONE : DRAIN) : IDLE;
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  // control: state, issue address (cleared after the last read) and return count
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_issue <= '0;
      r_ret   <= '0;
      err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_issue <= (w_start_go || w_last_issue) ? '0 : rd_en ? r_issue + ADDR_W'(1) : r_issue;
      r_ret   <= w_start_go ? '0 : w_ret_nxt;
      err     <= err || (fc_valid_out && ((r_state == IDLE) || (r_state == DONE)));
    end
  end
  // data path: strobe/last follow the RAM latency, data is registered off the RAM output
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v1        <= 1'b0;
      r_l1        <= 1'b0;
      valid_in_FC <= 1'b0;
      fc_last     <= 1'b0;
      fc_data     <= '0;
    end else begin
      r_v1        <= rd_en;
      r_l1        <= w_last_issue;
      valid_in_FC <= r_v1;
      fc_last     <= r_l1;
      fc_data     <= r_v1 ? rd_data : '0;
    end
  end
endmodule
